// File: rtl/hpdcache_pkg.sv
// Shared types for the PLRU access sequencer: operation kind/record and counter width.
// SETS/WAYS of the arbiter are expected to match the package geometry below.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_SETS  = 64;
  localparam int unsigned HPDCACHE_WAYS  = 4;
  localparam int unsigned HPDCACHE_SET_W = $clog2(HPDCACHE_SETS);
  localparam int unsigned HIT_DROP_CNT_W = 16;

  typedef enum logic {
    PLRU_OP_UPDT = 1'b0,
    PLRU_OP_REPL = 1'b1
  } plru_kind_e;

  typedef struct packed {
    plru_kind_e                  kind;
    logic [HPDCACHE_SET_W-1:0]   set;
    logic [HPDCACHE_WAYS-1:0]    way;
  } plru_op_t;

endpackage

// File: rtl/hpdcache_rrarb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// pointer moves to one past the winner when the grant is taken (en_i).
module hpdcache_rrarb #(
  parameter int unsigned REQS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [REQS-1:0] req_i,
  input  logic            en_i,
  output logic [REQS-1:0] gnt_o
);

  localparam int unsigned PTR_W = (REQS > 1) ? $clog2(REQS) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] win_idx;
  logic             found;

  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      idx = PTR_W'((32'(ptr_q) + i) % REQS);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_idx    = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = (win_idx == PTR_W'(REQS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hpdcache_plru_arbiter.sv
// Serialises hit updates and refill replacements onto the PLRU array, one op per cycle,
// with bounded replacement bursts, duplicate-update suppression and a drop counter.
module hpdcache_plru_arbiter
  import hpdcache_pkg::*;
#(
  parameter int unsigned SETS           = HPDCACHE_SETS,
  parameter int unsigned WAYS           = HPDCACHE_WAYS,
  parameter int unsigned REQS           = 2,
  parameter int unsigned REPL_BURST_MAX = 4,
  localparam int unsigned SETW          = $clog2(SETS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_updt_en_i,
  input  logic [REQS-1:0]                hit_valid_i,
  output logic [REQS-1:0]                hit_ready_o,
  input  logic [REQS-1:0][SETW-1:0]      hit_set_i,
  input  logic [REQS-1:0][WAYS-1:0]      hit_way_i,
  input  logic                           repl_valid_i,
  output logic                           repl_ready_o,
  input  logic [SETW-1:0]                repl_set_i,
  input  logic [WAYS-1:0]                repl_way_i,
  output logic                           plru_updt_o,
  output logic [SETW-1:0]                plru_updt_set_o,
  output logic [WAYS-1:0]                plru_updt_way_o,
  output logic                           plru_repl_o,
  output logic [SETW-1:0]                plru_repl_set_o,
  output logic [WAYS-1:0]                plru_repl_way_o,
  output logic [HIT_DROP_CNT_W-1:0]      hit_drop_cnt_o
);

  localparam int unsigned BW = $clog2(REPL_BURST_MAX + 1);

  logic [REQS-1:0] hit_gnt;
  logic            hit_pend, hit_win, repl_gnt, burst_max, hit_drop;
  logic [SETW-1:0] sel_set;
  logic [WAYS-1:0] sel_way;

  logic [BW-1:0]             burst_q, burst_d;
  logic                      last_vld_q, last_vld_d;
  logic [SETW-1:0]           last_set_q, last_set_d;
  logic [WAYS-1:0]           last_way_q, last_way_d;
  logic                      op_vld_q, op_vld_d;
  plru_op_t                  op_q, op_d;
  logic [HIT_DROP_CNT_W-1:0] cnt_q, cnt_d;

  // Replacement normally wins; a pending hit is forced through once the burst limit is hit.
  assign hit_pend  = |hit_valid_i;
  assign burst_max = (burst_q == BW'(REPL_BURST_MAX));
  assign hit_win   = hit_pend && (!repl_valid_i || burst_max);
  assign repl_gnt  = repl_valid_i && !hit_win;

  hpdcache_rrarb #(
    .REQS (REQS)
  ) i_rrarb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (hit_valid_i),
    .en_i  (hit_win),
    .gnt_o (hit_gnt)
  );

  assign hit_ready_o  = hit_win ? hit_gnt : '0;
  assign repl_ready_o = repl_gnt;

  always_comb begin
    sel_set = '0;
    sel_way = '0;
    for (int unsigned r = 0; r < REQS; r++) begin
      if (hit_gnt[r]) begin
        sel_set = sel_set | hit_set_i[r];
        sel_way = sel_way | hit_way_i[r];
      end
    end
  end

  // Re-applying the same (set,way) to an OR-style PLRU is a no-op, so it is suppressed.
  assign hit_drop = hit_win &&
                    (!cfg_updt_en_i ||
                     (last_vld_q && (last_set_q == sel_set) && (last_way_q == sel_way)));

  always_comb begin
    burst_d    = burst_q;
    last_vld_d = last_vld_q;
    last_set_d = last_set_q;
    last_way_d = last_way_q;
    op_vld_d   = 1'b0;
    op_d       = '0;
    cnt_d      = cnt_q;

    if (hit_win || !hit_pend) begin
      burst_d = '0;
    end else if (repl_gnt && !burst_max) begin
      burst_d = burst_q + 1'b1;
    end

    if (repl_gnt) begin
      op_vld_d   = 1'b1;
      op_d.kind  = PLRU_OP_REPL;
      op_d.set   = repl_set_i;
      op_d.way   = repl_way_i;
      last_vld_d = 1'b1;
      last_set_d = repl_set_i;
      last_way_d = repl_way_i;
    end else if (hit_win) begin
      if (hit_drop) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!cfg_updt_en_i) begin
          last_vld_d = 1'b0;
        end
      end else begin
        op_vld_d   = 1'b1;
        op_d.kind  = PLRU_OP_UPDT;
        op_d.set   = sel_set;
        op_d.way   = sel_way;
        last_vld_d = 1'b1;
        last_set_d = sel_set;
        last_way_d = sel_way;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      burst_q    <= '0;
      last_vld_q <= 1'b0;
      last_set_q <= '0;
      last_way_q <= '0;
      op_vld_q   <= 1'b0;
      op_q       <= '0;
      cnt_q      <= '0;
    end else begin
      burst_q    <= burst_d;
      last_vld_q <= last_vld_d;
      last_set_q <= last_set_d;
      last_way_q <= last_way_d;
      op_vld_q   <= op_vld_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
    end
  end

  assign plru_updt_o     = op_vld_q && (op_q.kind == PLRU_OP_UPDT);
  assign plru_repl_o     = op_vld_q && (op_q.kind == PLRU_OP_REPL);
  assign plru_updt_set_o = plru_updt_o ? op_q.set : '0;
  assign plru_updt_way_o = plru_updt_o ? op_q.way : '0;
  assign plru_repl_set_o = plru_repl_o ? op_q.set : '0;
  assign plru_repl_way_o = plru_repl_o ? op_q.way : '0;
  assign hit_drop_cnt_o  = cnt_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({hit_ready_o, repl_ready_o}));

  a_strobe_excl : assert property (@(posedge clk_i) disable iff (rst_i)
    !(plru_updt_o && plru_repl_o));

  a_hit_way_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    hit_win |-> $onehot(sel_way));

  a_repl_way_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    repl_gnt |-> $onehot(repl_way_i));

  a_repl_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (repl_valid_i && !repl_ready_o) |=>
      (repl_valid_i && $stable(repl_set_i) && $stable(repl_way_i)));

  for (genvar r = 0; r < REQS; r++) begin : g_hit_stable
    a_hit_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (hit_valid_i[r] && !hit_ready_o[r]) |=>
        (hit_valid_i[r] && $stable(hit_set_i[r]) && $stable(hit_way_i[r])));
  end

endmodule

// File: tb/tb_hpdcache_plru_arbiter.sv
// Scoreboard bench for the PLRU arbiter: a reference model predicts each cycle's grant
// and the registered op, which is queued and compared when the DUT presents it.
module tb_hpdcache_plru_arbiter;

  localparam int SETW = 6;
  localparam int MAXB = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg;
  logic [1:0]           hit_valid;
  logic [1:0]           hit_ready;
  logic [1:0][SETW-1:0] hit_set;
  logic [1:0][3:0]      hit_way;
  logic                 repl_valid;
  logic                 repl_ready;
  logic [SETW-1:0]      repl_set;
  logic [3:0]           repl_way;
  logic                 plru_updt, plru_repl;
  logic [SETW-1:0]      plru_updt_set, plru_repl_set;
  logic [3:0]           plru_updt_way, plru_repl_way;
  logic [15:0]          drop_cnt;

  always #5 clk = ~clk;

  hpdcache_plru_arbiter #(
    .SETS(64), .WAYS(4), .REQS(2), .REPL_BURST_MAX(MAXB)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_updt_en_i   (cfg),
    .hit_valid_i     (hit_valid),
    .hit_ready_o     (hit_ready),
    .hit_set_i       (hit_set),
    .hit_way_i       (hit_way),
    .repl_valid_i    (repl_valid),
    .repl_ready_o    (repl_ready),
    .repl_set_i      (repl_set),
    .repl_way_i      (repl_way),
    .plru_updt_o     (plru_updt),
    .plru_updt_set_o (plru_updt_set),
    .plru_updt_way_o (plru_updt_way),
    .plru_repl_o     (plru_repl),
    .plru_repl_set_o (plru_repl_set),
    .plru_repl_way_o (plru_repl_way),
    .hit_drop_cnt_o  (drop_cnt)
  );

  typedef struct {
    logic            updt;
    logic            repl;
    logic [SETW-1:0] set;
    logic [3:0]      way;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_updt   = 0;
  int n_repl   = 0;

  int              m_ptr, m_burst, m_drops;
  bit              m_lv;
  logic [SETW-1:0] m_ls;
  logic [3:0]      m_lw;

  int              h_rem[2];
  int              r_rem;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_burst = 0; m_drops = 0; m_lv = 0; m_ls = '0; m_lw = '0;
    sb_q.delete();
  endtask

  task automatic drive_valids();
    hit_valid[0] = (h_rem[0] > 0);
    hit_valid[1] = (h_rem[1] > 0);
    repl_valid   = (r_rem > 0);
  endtask

  // One clock: check registered outputs, predict and check this cycle's handshake.
  task automatic cycle();
    exp_t e;
    bit   hp, hw, rg, drop;
    int   win;
    logic [1:0] exp_rdy;
    logic [1:0] h_acc;
    logic       r_acc;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk_eq("updt", plru_updt, e.updt);
      chk_eq("repl", plru_repl, e.repl);
      chk_eq("updt_set", plru_updt_set, e.updt ? e.set : '0);
      chk_eq("updt_way", plru_updt_way, e.updt ? e.way : '0);
      chk_eq("repl_set", plru_repl_set, e.repl ? e.set : '0);
      chk_eq("repl_way", plru_repl_way, e.repl ? e.way : '0);
    end
    chk_eq("drop_cnt", drop_cnt, m_drops);
    n_updt += int'(plru_updt);
    n_repl += int'(plru_repl);

    hp  = (hit_valid != 2'b00);
    hw  = hp && (!repl_valid || m_burst == MAXB);
    rg  = repl_valid && !hw;
    win = -1;
    if (hw) begin
      for (int i = 0; i < 2; i++) begin
        if (win < 0 && hit_valid[(m_ptr + i) % 2]) win = (m_ptr + i) % 2;
      end
    end
    exp_rdy = (win >= 0) ? (2'b01 << win) : 2'b00;
    chk_eq("hit_ready", hit_ready, exp_rdy);
    chk_eq("repl_ready", repl_ready, rg);

    e = '{updt: 1'b0, repl: 1'b0, set: '0, way: '0};
    if (rg) begin
      e.repl = 1'b1; e.set = repl_set; e.way = repl_way;
      m_lv = 1; m_ls = repl_set; m_lw = repl_way;
    end else if (win >= 0) begin
      drop = !cfg || (m_lv && m_ls == hit_set[win] && m_lw == hit_way[win]);
      if (drop) begin
        if (m_drops < 16'hFFFF) m_drops++;
        if (!cfg) m_lv = 0;
      end else begin
        e.updt = 1'b1; e.set = hit_set[win]; e.way = hit_way[win];
        m_lv = 1; m_ls = hit_set[win]; m_lw = hit_way[win];
      end
      m_ptr = (win + 1) % 2;
    end
    if (hw || !hp) m_burst = 0;
    else if (rg && m_burst < MAXB) m_burst++;
    sb_q.push_back(e);

    h_acc = hit_valid & hit_ready;
    r_acc = repl_valid && repl_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) if (h_acc[k] && h_rem[k] > 0) h_rem[k]--;
    if (r_acc && r_rem > 0) r_rem--;
    drive_valids();
  endtask

  task automatic run_scn(input int n0, input int s0, input logic [3:0] w0,
                         input int n1, input int s1, input logic [3:0] w1,
                         input int nr, input int sr, input logic [3:0] wr,
                         input bit c, output int cycles);
    h_rem[0] = n0; hit_set[0] = SETW'(s0); hit_way[0] = w0;
    h_rem[1] = n1; hit_set[1] = SETW'(s1); hit_way[1] = w1;
    r_rem    = nr; repl_set   = SETW'(sr); repl_way   = wr;
    cfg      = c;
    drive_valids();
    cycles = 0;
    while ((h_rem[0] > 0 || h_rem[1] > 0 || r_rem > 0) && cycles < 60) begin
      cycle();
      cycles++;
    end
    if (h_rem[0] > 0 || h_rem[1] > 0 || r_rem > 0) chk_eq("timeout", 32'd1, 32'd0);
    cycle();
  endtask

  int cyc, u0, r0;
  logic [15:0] d0;

  initial begin
    rst = 1'b1; cfg = 1'b1;
    hit_valid = '0; hit_set = '0; hit_way = '0;
    repl_valid = 1'b0; repl_set = '0; repl_way = '0;
    h_rem[0] = 0; h_rem[1] = 0; r_rem = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_updt", plru_updt, 0);
    chk_eq("rst_repl", plru_repl, 0);
    chk_eq("rst_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb_q.push_back('{updt: 1'b0, repl: 1'b0, set: '0, way: '0});

    u0 = n_updt; r0 = n_repl; d0 = drop_cnt;
    run_scn(1, 5, 4'b0010, 0, 0, 4'b0, 0, 0, 4'b0, 1'b1, cyc);
    chk_eq("s1_cycles", cyc, 1);
    chk_eq("s1_updt", n_updt - u0, 1);

    u0 = n_updt; r0 = n_repl;
    run_scn(0, 0, 4'b0, 1, 7, 4'b0100, 1, 3, 4'b0001, 1'b1, cyc);
    chk_eq("s2_cycles", cyc, 2);
    chk_eq("s2_updt", n_updt - u0, 1);
    chk_eq("s2_repl", n_repl - r0, 1);

    u0 = n_updt; r0 = n_repl;
    run_scn(2, 10, 4'b0001, 0, 0, 4'b0, 8, 11, 4'b0010, 1'b1, cyc);
    chk_eq("s3_cycles", cyc, 10);
    chk_eq("s3_updt", n_updt - u0, 2);
    chk_eq("s3_repl", n_repl - r0, 8);

    u0 = n_updt;
    run_scn(3, 20, 4'b0001, 3, 21, 4'b0010, 0, 0, 4'b0, 1'b1, cyc);
    chk_eq("s4_cycles", cyc, 6);
    chk_eq("s4_updt", n_updt - u0, 6);

    u0 = n_updt; d0 = drop_cnt;
    run_scn(2, 2, 4'b1000, 0, 0, 4'b0, 0, 0, 4'b0, 1'b1, cyc);
    chk_eq("s5_cycles", cyc, 2);
    chk_eq("s5_updt", n_updt - u0, 1);
    chk_eq("s5_drops", 32'(drop_cnt - d0), 1);

    u0 = n_updt; r0 = n_repl; d0 = drop_cnt;
    run_scn(3, 9, 4'b0100, 0, 0, 4'b0, 1, 12, 4'b0001, 1'b0, cyc);
    chk_eq("s6_cycles", cyc, 4);
    chk_eq("s6_updt", n_updt - u0, 0);
    chk_eq("s6_repl", n_repl - r0, 1);
    chk_eq("s6_drops", 32'(drop_cnt - d0), 3);

    for (int it = 0; it < 25; it++) begin
      run_scn($urandom_range(0, 4), $urandom_range(0, 1), 4'b0001 << $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 1), 4'b0001 << $urandom_range(0, 3),
              $urandom_range(0, 6), $urandom_range(0, 1), 4'b0001 << $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
